// File: rtl/seq_alu.sv
// Registered AC/DR ALU with an E flag, a multi-cycle shift-add multiply and a
// restoring divide, sequenced by a START/BUSY/DONE handshake.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [3:0]       OPSEL,
  input  logic [WIDTH-1:0] AC,
  input  logic [WIDTH-1:0] DR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             E,
  output logic             CO,
  output logic             OVF,
  output logic             N,
  output logic             Z,
  output logic             DIV0
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_CMA = 4'b0011;
  localparam logic [3:0] OP_CIR = 4'b0100;
  localparam logic [3:0] OP_CIL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_ADC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_CLE = 4'b1010;
  localparam logic [3:0] OP_CME = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] opb;
  // Multiply: {hi,lo} is the partial product. Divide: hi is the remainder, lo the quotient.
  logic [WIDTH-1:0] hi, lo;

  logic            is_multi, last, complete;
  logic            is_sub, cin, add_ovf;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]  add_sum;
  logic [WIDTH:0]  mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

  logic [WIDTH-1:0] res_d, hi_d;
  logic            e_d, co_d, ovf_d, div0_d;

  assign BUSY     = (state != S_IDLE);
  assign is_multi = (OPSEL == OP_MUL) || ((OPSEL == OP_DIV) && (DR != '0));
  assign last     = (count == CW'(1));

  assign is_sub  = (OPSEL == OP_SUB);
  assign b_eff   = is_sub ? ~DR : DR;
  assign cin     = is_sub ? 1'b1 : ((OPSEL == OP_ADC) ? E : 1'b0);
  assign add_sum = {1'b0, AC} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign add_ovf = (AC[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != AC[WIDTH-1]);

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

  // A negative trial difference wraps into the top bit, which then means "restore".
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (START && is_multi) state_next = (OPSEL == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    complete = 1'b0;
    res_d    = RESULT;
    hi_d     = '0;
    e_d      = E;
    co_d     = 1'b0;
    ovf_d    = 1'b0;
    div0_d   = 1'b0;
    if (state == S_IDLE && START && !is_multi) begin
      complete = 1'b1;
      case (OPSEL)
        OP_ADD, OP_SUB, OP_ADC: begin
          res_d = add_sum[WIDTH-1:0];
          co_d  = add_sum[WIDTH];
          e_d   = add_sum[WIDTH];
          ovf_d = add_ovf;
        end
        OP_AND: res_d = AC & DR;
        OP_LDA: res_d = DR;
        OP_CMA: res_d = ~AC;
        OP_CIR: begin
          res_d = {E, AC[WIDTH-1:1]};
          co_d  = AC[0];
          e_d   = AC[0];
        end
        OP_CIL: begin
          res_d = {AC[WIDTH-2:0], E};
          co_d  = AC[WIDTH-1];
          e_d   = AC[WIDTH-1];
        end
        OP_DIV: begin
          res_d  = '1;
          hi_d   = AC;
          ovf_d  = 1'b1;
          div0_d = 1'b1;
        end
        OP_CLE: e_d = 1'b0;
        OP_CME: e_d = ~E;
        default: ;
      endcase
    end else if (state == S_MUL && last) begin
      complete = 1'b1;
      res_d    = mul_lo_n;
      hi_d     = mul_hi_n;
      co_d     = (mul_hi_n != '0);
      ovf_d    = (mul_hi_n != '0);
    end else if (state == S_DIV && last) begin
      complete = 1'b1;
      res_d    = div_lo_n;
      hi_d     = div_hi_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
      DONE      <= 1'b0;
      RESULT    <= '0;
      RESULT_HI <= '0;
      E         <= 1'b0;
      CO        <= 1'b0;
      OVF       <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
      DIV0      <= 1'b0;
    end else begin
      DONE <= complete;
      if (state == S_IDLE && START && is_multi) begin
        opb   <= DR;
        hi    <= '0;
        lo    <= AC;
        count <= CW'(WIDTH);
      end else if (state == S_MUL) begin
        hi    <= mul_hi_n;
        lo    <= mul_lo_n;
        count <= count - CW'(1);
      end else if (state == S_DIV) begin
        hi    <= div_hi_n;
        lo    <= div_lo_n;
        count <= count - CW'(1);
      end
      if (complete) begin
        RESULT    <= res_d;
        RESULT_HI <= hi_d;
        E         <= e_d;
        CO        <= co_d;
        OVF       <= ovf_d;
        DIV0      <= div0_d;
        N         <= res_d[WIDTH-1];
        Z         <= (res_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: table of single ops and multi-cycle ops checked through a
// scoreboard queue, plus hand sequences for ignored START and reset abort.
module tb_seq_alu;

  localparam int W = 16;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] ac;
    logic [15:0] dr;
    logic [15:0] res;
    logic [15:0] hi;
    logic        e;
    logic        co;
    logic        ovf;
    logic        n;
    logic        z;
    logic        div0;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opsel;
  logic [15:0] ac, dr;
  logic        busy, done, e, co, ovf, n, z, div0;
  logic [15:0] result, result_hi;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t tbl[26];
  logic [15:0] exp_res_last = '0;
  logic        exp_e = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .START(start), .OPSEL(opsel), .AC(ac), .DR(dr),
    .BUSY(busy), .DONE(done), .RESULT(result), .RESULT_HI(result_hi),
    .E(e), .CO(co), .OVF(ovf), .N(n), .Z(z), .DIV0(div0)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic [15:0] h, input logic ee,
                              input logic c, input logic v, input logic nn, input logic zz,
                              input logic d0, input int lat);
    vec_t t;
    t.op = op; t.ac = a; t.dr = b; t.res = r; t.hi = h; t.e = ee;
    t.co = c; t.ovf = v; t.n = nn; t.z = zz; t.div0 = d0; t.lat = lat;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_output(input string tag, input vec_t x, input int cycles);
    check({tag, ".latency"}, cycles, x.lat);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".result"}, result, x.res);
    check({tag, ".result_hi"}, result_hi, x.hi);
    check({tag, ".e"}, e, x.e);
    check({tag, ".co"}, co, x.co);
    check({tag, ".ovf"}, ovf, x.ovf);
    check({tag, ".n"}, n, x.n);
    check({tag, ".z"}, z, x.z);
    check({tag, ".div0"}, div0, x.div0);
    exp_res_last = x.res;
    exp_e = x.e;
  endtask

  // Called at a negedge; drives START, waits for DONE and compares against the popped entry.
  task automatic apply_stimulus(input string tag, input vec_t v);
    int cycles;
    vec_t x;
    start = 1'b1; opsel = v.op; ac = v.ac; dr = v.dr;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s.done_timeout: got no DONE expected DONE within 100 cycles", tag);
      sb.delete();
    end else begin
      x = sb.pop_front();
      check_output(tag, x, cycles);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = mk(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 1, 1, 0, 0, 1);
    tbl[1]  = mk(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0, 0, 1, 0, 1);
    tbl[2]  = mk(4'b0101, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 1, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(4'b1011, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(4'b0110, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[5]  = mk(4'b1011, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 1, 0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(4'b0111, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(4'b0001, 16'hF0F0, 16'h3CFF, 16'h30F0, 16'h0000, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(4'b0010, 16'h1234, 16'h8001, 16'h8001, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[9]  = mk(4'b0011, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[10] = mk(4'b0100, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 1, 1, 0, 0, 0, 0, 1);
    tbl[11] = mk(4'b0100, 16'h0002, 16'h0000, 16'h8001, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(4'b1011, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 1, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(4'b1010, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[14] = mk(4'b1100, 16'h5555, 16'hAAAA, 16'h8001, 16'h0000, 0, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(4'b0110, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1, 1, 1, 0, 0, 0, 1);
    tbl[16] = mk(4'b0000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 1, 1, 0, 1, 0, 1);
    tbl[17] = mk(4'b1111, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0, 1);
    tbl[18] = mk(4'b1000, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 1, 1, 0, 0, 0, 17);
    tbl[19] = mk(4'b1001, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1, 0, 0, 0, 0, 0, 17);
    tbl[20] = mk(4'b1001, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1, 0, 1, 1, 0, 1, 1);
    tbl[21] = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 1);
    tbl[22] = mk(4'b1000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 1, 0, 0, 0, 17);
    tbl[23] = mk(4'b1000, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 0, 0, 0, 0, 0, 0, 17);
    tbl[24] = mk(4'b1001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 0, 17);
    tbl[25] = mk(4'b1001, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 0, 0, 0, 0, 1, 0, 17);

    rst_n = 1'b0; start = 1'b0; opsel = '0; ac = '0; dr = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.result", result, 0);
    check("reset.result_hi", result_hi, 0);
    check("reset.flags", {e, co, ovf, n, z, div0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive calls issue START in the DONE cycle of the previous op.
    for (int i = 0; i < 26; i++) apply_stimulus($sformatf("v%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] a, b;
      logic [31:0] p;
      vec_t t;
      a = 16'($urandom_range(0, 65535));
      if (i % 2 == 0) begin
        b = 16'($urandom_range(0, 65535));
        p = {16'h0, a} * {16'h0, b};
        t = mk(4'b1000, a, b, p[15:0], p[31:16], exp_e, p[31:16] != 0, p[31:16] != 0,
               p[15], p[15:0] == 0, 0, 17);
      end else begin
        b = 16'($urandom_range(1, 300));
        t = mk(4'b1001, a, b, a / b, a % b, exp_e, 0, 0, (a / b) >> 15, (a / b) == 0, 0, 17);
      end
      apply_stimulus($sformatf("rnd%0d", i), t);
    end

    // MUL with a START pulse and operand changes while busy; outputs must hold.
    begin
      vec_t m;
      logic [15:0] held;
      held = exp_res_last;
      m = mk(4'b1000, 16'h1234, 16'h0100, 16'h3400, 16'h0012, exp_e, 1, 1, 0, 0, 0, 17);
      start = 1'b1; opsel = m.op; ac = m.ac; dr = m.dr;
      sb.push_back(m);
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        start = (c == 4);
        opsel = 4'b0000; ac = 16'(c); dr = 16'hFFFF;
        check($sformatf("seqA.busy%0d", c), busy, 1);
        check($sformatf("seqA.done%0d", c), done, 0);
        check($sformatf("seqA.hold%0d", c), result, held);
      end
      @(negedge clk);
      check("seqA.done17", done, 1);
      if (done && sb.size() > 0) check_output("seqA", sb.pop_front(), 17);
      @(negedge clk);
      check("seqA.no_queued_done", done, 0);
      check("seqA.idle", busy, 0);
    end

    // Reset in cycle t+8 of a MUL aborts it with no DONE.
    begin
      int seen;
      start = 1'b1; opsel = 4'b1000; ac = 16'hFFFF; dr = 16'hFFFF;
      sb.push_back(mk(4'b1000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 1, 0, 0, 0, 17));
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("seqB.busy", busy, 0);
      check("seqB.done", done, 0);
      check("seqB.result", result, 0);
      check("seqB.result_hi", result_hi, 0);
      check("seqB.flags", {e, co, ovf, n, z, div0}, 0);
      exp_e = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("seqB.no_done", seen, 0);
      apply_stimulus("seqB.add", mk(4'b0000, 16'h0002, 16'h0003, 16'h0005, 16'h0000,
                                    0, 0, 0, 0, 0, 0, 1));
    end

    check("scoreboard.empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
